// File: rtl/wshb_fb_slave_if.sv
// Wishbone classic bus bundle shared by the frame-buffer slave and its masters.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    input  clk, rst,
    output adr, dat_ms, sel, we, cyc, stb, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  clk, rst,
    input  adr, dat_ms, sel, we, cyc, stb, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wshb_fb_slave.sv
// Wishbone classic slave holding one frame of 32-bit pixels (one word per pixel).
// Optional feature: define WSHB_FB_ERR_EN to answer out-of-range accesses with err
// instead of ack; by default they are acked, reads return zero and writes are dropped.
module wshb_fb_slave #(
  parameter int unsigned HDISP       = 800,
  parameter int unsigned VDISP       = 480,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000
) (
  wshb_if.slave wshb_ifs
);

  localparam int unsigned DEPTH       = HDISP * VDISP;
  localparam int unsigned IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] FRAME_BYTES = 32'(4 * DEPTH);
  localparam logic [3:0]  WS_LAST     = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        wait_cnt;
  logic [3:0]        wait_cnt_next;

  // latched request
  logic [31:0]       adr_q;
  logic [31:0]       dat_q;
  logic [3:0]        sel_q;
  logic              we_q;

  // request view: live bus while idle, latched copy afterwards
  logic              req_c;
  logic              capture_c;
  logic [31:0]       req_adr_c;
  logic [31:0]       req_off_c;
  logic              req_we_c;
  logic              req_in_range_c;
  logic [IDX_W-1:0]  req_idx_c;

  logic              ack_next;
  logic              err_next;
  logic              dat_load;
  logic [31:0]       dat_next;
  logic              mem_we;

  logic              ack_q;
  logic              err_q;
  logic [31:0]       dat_sm_q;

  logic [31:0]       mem [DEPTH];

  logic              unused_c;

  // burst signalling is not supported; every access is a classic cycle
  assign unused_c = ^{wshb_ifs.cti, wshb_ifs.bte};

  assign req_c = wshb_ifs.cyc & wshb_ifs.stb;

  // state register and wait counter
  always_ff @(posedge wshb_ifs.clk) begin
    if (wshb_ifs.rst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // next-state logic: capture in idle, count wait states, abort if the master retracts
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      S_IDLE: begin
        if (req_c) begin
          if (WAIT_STATES > 0) begin
            state_next    = S_WAIT;
            wait_cnt_next = 4'd1;
          end else begin
            state_next    = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (!req_c) begin
          state_next    = S_IDLE;
          wait_cnt_next = 4'd0;
        end else if (wait_cnt == WS_LAST) begin
          state_next    = S_RESP;
          wait_cnt_next = 4'd0;
        end else begin
          wait_cnt_next = wait_cnt + 4'd1;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next    = S_IDLE;
        wait_cnt_next = 4'd0;
      end
    endcase
  end

  // output logic: response kind, read data and RAM write enable
  always_comb begin
    capture_c      = (state == S_IDLE) && req_c;
    req_adr_c      = (state == S_IDLE) ? wshb_ifs.adr : adr_q;
    req_we_c       = (state == S_IDLE) ? wshb_ifs.we  : we_q;
    req_off_c      = req_adr_c - BASE_ADR;
    req_in_range_c = req_off_c < FRAME_BYTES;
    req_idx_c      = req_off_c[IDX_W+1:2];

    ack_next = 1'b0;
    err_next = 1'b0;
    dat_load = 1'b0;
    dat_next = dat_sm_q;

    // response is registered so it lands exactly in the RESP cycle
    if ((state_next == S_RESP) && (state != S_RESP)) begin
`ifdef WSHB_FB_ERR_EN
      if (req_in_range_c) begin
        ack_next = 1'b1;
        if (!req_we_c) begin
          dat_load = 1'b1;
          dat_next = mem[req_idx_c];
        end
      end else begin
        err_next = 1'b1;
      end
`else
      ack_next = 1'b1;
      if (!req_we_c) begin
        dat_load = 1'b1;
        dat_next = req_in_range_c ? mem[req_idx_c] : 32'h0;
      end
`endif
    end

    // write lands in RESP, so a following read always sees it
    mem_we = (state == S_RESP) && we_q && req_in_range_c && !wshb_ifs.rst;
  end

  // request capture
  always_ff @(posedge wshb_ifs.clk) begin
    if (wshb_ifs.rst) begin
      adr_q <= 32'h0;
      dat_q <= 32'h0;
      sel_q <= 4'h0;
      we_q  <= 1'b0;
    end else if (capture_c) begin
      adr_q <= wshb_ifs.adr;
      dat_q <= wshb_ifs.dat_ms;
      sel_q <= wshb_ifs.sel;
      we_q  <= wshb_ifs.we;
    end
  end

  // registered bus outputs
  always_ff @(posedge wshb_ifs.clk) begin
    if (wshb_ifs.rst) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_sm_q <= 32'h0;
    end else begin
      ack_q <= ack_next;
      err_q <= err_next;
      if (dat_load) begin
        dat_sm_q <= dat_next;
      end
    end
  end

  // frame RAM, byte-lane write
  always_ff @(posedge wshb_ifs.clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) begin
          mem[req_idx_c][8*i +: 8] <= dat_q[8*i +: 8];
        end
      end
    end
  end

  assign wshb_ifs.ack    = ack_q;
  assign wshb_ifs.err    = err_q;
  assign wshb_ifs.rty    = 1'b0;
  assign wshb_ifs.dat_sm = dat_sm_q;

endmodule

// File: tb/tb_wshb_fb_slave.sv
// Scoreboard bench for wshb_fb_slave on a reduced 8x4 frame.
module tb_wshb_fb_slave;

  localparam int unsigned HDISP = 8;
  localparam int unsigned VDISP = 4;
  localparam int unsigned WS    = 1;
  localparam int unsigned DEPTH = HDISP * VDISP;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef WSHB_FB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic        is_err;
    logic        chk_dat;
    logic [31:0] dat;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc_n = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] last_dat = 32'h0;

  wshb_if bus (.clk(clk), .rst(rst));

  wshb_fb_slave #(
    .HDISP(HDISP), .VDISP(VDISP), .WAIT_STATES(WS), .BASE_ADR(BASE)
  ) dut (
    .wshb_ifs(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic push(input logic is_err, input logic chk, input logic [31:0] d, input int c);
    exp_t e;
    e.is_err  = is_err;
    e.chk_dat = chk;
    e.dat     = d;
    e.cyc     = 32'(c);
    exp_q.push_back(e);
  endtask

  // monitor: every response is popped and compared against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (bus.ack === 1'b1 || bus.err === 1'b1) begin
      check("ack_err_exclusive", 32'(bus.ack & bus.err), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_response", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("resp_kind_err", 32'(bus.err), 32'(e.is_err));
        check("resp_cycle", 32'(cyc_n), e.cyc);
        if (e.chk_dat) check("resp_data", bus.dat_sm, e.dat);
      end
    end
  end

  // wait for ack/err with a bound; called at a negedge, returns at a negedge
  task automatic wait_resp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1 || bus.err === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("resp_seen", 32'(got), 32'd1);
    if (!got && exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    bus.cyc = 1'b1; bus.stb = 1'b1;
    bus.adr = a; bus.we = w; bus.dat_ms = d; bus.sel = s;
  endtask

  task automatic release_bus();
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
  endtask

  function automatic bit in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got;
    push(ERR_EN && !in_range(a), 1'b0, 32'h0, cyc_n + 1 + int'(WS));
    drive(a, 1'b1, d, s);
    wait_resp(got);
    release_bus();
    if (in_range(a)) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) mdl[widx(a)][8*i +: 8] = d[8*i +: 8];
    end
    @(negedge clk);
  endtask

  task automatic wb_read(input logic [31:0] a);
    bit got;
    logic [31:0] exp;
    if (in_range(a)) exp = mdl[widx(a)];
    else if (ERR_EN) exp = last_dat;
    else exp = 32'h0;
    push(ERR_EN && !in_range(a), 1'b1, exp, cyc_n + 1 + int'(WS));
    drive(a, 1'b0, 32'h0, 4'hF);
    wait_resp(got);
    release_bus();
    last_dat = exp;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int idx;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = 32'h0; bus.dat_ms = 32'h0; bus.sel = 4'h0;
    bus.cti = 3'b000; bus.bte = 2'b00;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_ack", 32'(bus.ack), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    check("reset_rty", 32'(bus.rty), 32'd0);
    check("reset_dat_sm", bus.dat_sm, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // preload index pattern
    for (int i = 0; i < int'(DEPTH); i++)
      wb_write(BASE + 32'(4 * i), 32'hA500_0000 | 32'(i), 4'hF);

    // basic write/read
    wb_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    wb_read(BASE + 32'h10);
    check("basic_model", mdl[4], 32'hDEAD_BEEF);

    // byte lanes, plus sel=0 writing nothing
    wb_write(BASE + 32'h20, 32'h1122_3344, 4'hF);
    wb_write(BASE + 32'h20, 32'hAABB_CCDD, 4'b0101);
    wb_read(BASE + 32'h20);
    check("lane_model", mdl[8], 32'h11BB_33DD);
    wb_write(BASE + 32'h20, 32'h5566_7788, 4'b0000);
    wb_read(BASE + 32'h20);

    // streaming read with stb held, wrapping back to word 0
    drive(BASE, 1'b0, 32'h0, 4'hF);
    push(1'b0, 1'b1, mdl[0], cyc_n + 1 + int'(WS));
    for (int k = 0; k <= int'(DEPTH); k++) begin
      wait_resp(got);
      if (!got) break;
      last_dat = mdl[k % int'(DEPTH)];
      if (k < int'(DEPTH)) begin
        idx = (k + 1) % int'(DEPTH);
        bus.adr = BASE + 32'(4 * idx);
        push(1'b0, 1'b1, mdl[idx], cyc_n + 2 + int'(WS));
      end
    end
    release_bus();
    repeat (2) @(negedge clk);

    // abort during wait: no ack, no RAM change
    drive(BASE + 32'h30, 1'b1, 32'h0BAD_0BAD, 4'hF);
    @(negedge clk);
    release_bus();
    repeat (4) @(negedge clk);
    wb_read(BASE + 32'h30);
    wb_write(BASE + 32'h30, 32'h0BAD_0BAD, 4'hF);
    wb_read(BASE + 32'h30);

    // out of range: just past the frame and below/wrapped address
    wb_read(BASE + 32'(4 * DEPTH));
    wb_write(BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF);
    wb_read(BASE - 32'd4);
    wb_read(BASE + 32'(4 * (DEPTH - 1)));
    wb_read(BASE);

    // reset during wait of a write
    drive(BASE + 32'h40, 1'b1, 32'h1234_5678, 4'hF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ack", 32'(bus.ack), 32'd0);
    check("rst_mid_err", 32'(bus.err), 32'd0);
    check("rst_mid_dat_sm", bus.dat_sm, 32'h0);
    release_bus();
    @(negedge clk);
    rst = 1'b0;
    last_dat = 32'h0;
    @(negedge clk);
    wb_read(BASE + 32'h40);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
